// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states and the {pc, instr} queue entry.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry queue of fetch entries with push/pop/clear; head is read from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, wrapping pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: one outstanding imem read per accepted PC, responses queued in order for decode.
// Optional FETCH_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              misalign_err
);

    fetch_state_e         state_q;
    logic [ADDR_W-1:0]    pc_lat_q;
    logic                 misalign_q;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    fetch_entry_t         push_data_s;
    fetch_entry_t         head_s;
    logic [$clog2(DEPTH):0] count_s;

    // Issue only from IDLE with a free slot reserved for the response; flush suppresses issue.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = {ADDR_W{1'b0}};
        if (state_q == IDLE) begin
            imem_req  = pc_valid & ~flush & ~fifo_full_s;
            imem_addr = imem_req ? pc_in : {ADDR_W{1'b0}};
        end else begin
            imem_req  = 1'b0;
            imem_addr = {ADDR_W{1'b0}};
        end
    end

    assign pc_ready     = imem_req & imem_gnt;
    assign push_s       = (state_q == WAIT) & imem_rvalid & ~flush;
    assign pop_s        = id_valid & id_ready & ~flush;
    assign push_data_s  = '{pc: pc_lat_q, instr: imem_rdata};
    assign id_valid     = ~fifo_empty_s;
    assign id_instr     = head_s.instr;
    assign id_pc        = head_s.pc;
    assign misalign_err = misalign_q;

    // Fetch FSM: latch accepted PC, then wait for (or discard) the single outstanding response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_lat_q   <= {ADDR_W{1'b0}};
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_ready) begin
                        pc_lat_q <= pc_in;
                        state_q  <= WAIT;
                        if (pc_in[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .clear_i     (flush),
        .head_o      (head_s),
        .count_o     (count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Saturating counters for decode starvation and taken-branch flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (id_ready && !id_valid && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`endif

endmodule
